img_window_feeder: RTL and testbench
====================================

IMG_WINDOW_FEEDER -- requirements
Module: img_window_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 320, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 240, image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 17, pixel address width.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 go  in  1  host pulse requesting one full-image pass.
REQ-007 busy  out  1  high from go acceptance until drain complete.
REQ-008 start  out  1  one-cycle pulse on go acceptance, to the processing element.
REQ-009 cnt_start  out  1  one-cycle pulse one cycle before the first valid window.
REQ-010 done  out  1  one-cycle pulse coincident with the last valid window.
REQ-011 rd_en0/1/2  out  1  source-memory read enables for rows y-1, y, y+1.
REQ-012 rd_addr0/1/2  out  ADDR_W  source-memory read addresses, row*IMG_W+col.
REQ-013 rd_data0/1/2  in  12  RGB444 read data, valid exactly one cycle after rd_en.
REQ-014 win_row0/1/2  out  36  3x3 window rows y-1, y, y+1; [35:24]=x-1, [23:12]=x, [11:0]=x+1.
REQ-015 wr_addr  out  ADDR_W  result address y*IMG_W+x, delayed one cycle from its window.
REQ-016 wr_valid  out  1  window-valid delayed one cycle; memory write strobe = we_reg AND wr_valid.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on go, RUN->DRAIN after last row slot, DRAIN->IDLE after 2 cycles.
REQ-018 SHALL ignore go while busy.
REQ-019 SHALL in RUN sweep row y=0..IMG_H-1, each row using slot counter k=0..IMG_W+1 (IMG_W+2 cycles per row, no inter-row gap).
REQ-020 SHALL at slot k<IMG_W issue column c=k on all three ports; slots IMG_W, IMG_W+1 issue no read.
REQ-021 SHALL deassert rd_en0 for y=0 and rd_en2 for y=IMG_H-1; masked ports SHALL contribute 12'h000 (mask registered to match read latency).
REQ-022 SHALL hold a 3-column shift register (L,M,R) per row; returned column c lands in R at slot c+1, shifting R->M->L.
REQ-023 SHALL clear L,M at row slot 0 and shift zero into R at slot IMG_W+1 (left/right zero padding).
REQ-024 SHALL mark window valid at slots 2..IMG_W+1, center x=k-2; win_row outputs registered.
REQ-025 SHALL pulse cnt_start at row 0 slot 1 only.
REQ-026 SHALL pulse done at row IMG_H-1 slot IMG_W+1, same cycle as last window.
REQ-027 SHALL produce exactly IMG_W*IMG_H valid windows per pass, run length IMG_H*(IMG_W+2) cycles.
REQ-028 SHALL keep busy high through DRAIN so the final result write completes before busy falls.
REQ-029 Address arithmetic SHALL be unsigned ADDR_W bits; no address SHALL exceed IMG_W*IMG_H-1.

Reset
REQ-030 rst SHALL force IDLE, clear counters, shift registers, masks, and drive all outputs to 0.
REQ-031 rst mid-RUN or mid-DRAIN SHALL abort on the next edge with no done pulse; next go starts from row 0.
REQ-032 rst and go in the same cycle: rst wins; go is dropped.

Verification
REQ-033 IMG_W=4, IMG_H=3, go -> start same cycle, busy high, 18 RUN cycles, 12 valid windows, cnt_start at cycle 1, done at cycle 17.
REQ-034 Memory pixel p=address+1, row 1 center x=0 -> win_row0={000,001,002}, win_row1={000,005,006}, win_row2={000,009,00A}.
REQ-035 Row 0 windows -> win_row0 all zero, rd_en0 never asserted; row 2 -> win_row2 zero, rd_en2 never asserted.
REQ-036 wr_addr sequence 0..11 with wr_valid, one cycle after each window; two invalid cycles between rows.
REQ-037 go pulsed during RUN -> ignored, window count unchanged; busy falls 2 cycles after done.
REQ-038 rst asserted at row 1 slot 3 -> all outputs 0 next cycle, no done; fresh go -> full correct pass.

Source files
------------

// File: rtl/img_window_feeder.sv
//------------------------------------------------------------------------------
// Module  : img_window_feeder
// Purpose : Sweeps an image through three row read ports and presents zero-padded 3x3 windows.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module img_window_feeder #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              start,
  output logic              cnt_start,
  output logic              done,
  output logic              rd_en0,
  output logic              rd_en1,
  output logic              rd_en2,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [11:0]       rd_data0,
  input  logic [11:0]       rd_data1,
  input  logic [11:0]       rd_data2,
  output logic [35:0]       win_row0,
  output logic [35:0]       win_row1,
  output logic [35:0]       win_row2,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid
);

  localparam int KW = $clog2(IMG_W + 2);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [KW-1:0]     K_LAST = KW'(IMG_W + 1);
  localparam logic [KW-1:0]     K_RD   = KW'(IMG_W);
  localparam logic [KW-1:0]     K_TWO  = KW'(2);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [YW-1:0]          y_q, y_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic                   drain_q, drain_d;
  logic [2:0]             en_q, en_d;
  logic [2:0][11:0]       l_q, l_d, m_q, m_d, r_q, r_d;
  logic [2:0][35:0]       win_q, win_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   wr_valid_q, wr_valid_d;

  logic                   run, rd_slot, last_k, last_y, win_valid;
  logic [2:0]             rd_en;
  logic [2:0][ADDR_W-1:0] rd_addr;
  logic [2:0][11:0]       rd_data, data_in;
  logic [ADDR_W-1:0]      col_a;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    y_d        = y_q;
    base_d     = base_q;
    drain_d    = drain_q;
    l_d        = l_q;
    m_d        = m_q;
    r_d        = r_q;

    run       = (state_q == S_RUN);
    last_k    = (k_q == K_LAST);
    last_y    = (y_q == Y_LAST);
    rd_slot   = run && (k_q < K_RD);
    win_valid = run && (k_q >= K_TWO);
    col_a     = ADDR_W'(k_q);
    rd_data   = {rd_data2, rd_data1, rd_data0};

    // Outer rows vanish at the image top/bottom; addresses stay 0 when idle.
    rd_en[0] = rd_slot && (y_q != '0);
    rd_en[1] = rd_slot;
    rd_en[2] = rd_slot && !last_y;
    rd_addr[0] = rd_en[0] ? (base_q - W_A + col_a) : '0;
    rd_addr[1] = rd_en[1] ? (base_q + col_a)       : '0;
    rd_addr[2] = rd_en[2] ? (base_q + W_A + col_a) : '0;

    for (int p = 0; p < 3; p++) begin
      data_in[p] = en_q[p] ? rd_data[p] : 12'h000;
      win_d[p]   = win_valid ? {m_q[p], r_q[p], data_in[p]} : 36'h0;
    end
    en_d       = rd_en;
    wr_addr_d  = win_valid ? (base_q + col_a - ADDR_W'(2)) : '0;
    wr_valid_d = win_valid;

    if (run) begin
      if (k_q == '0) begin
        l_d = '0;
        m_d = '0;
        r_d = '0;
      end else begin
        l_d = m_q;
        m_d = r_q;
        r_d = data_in;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_RUN;
          k_d     = '0;
          y_d     = '0;
          base_d  = '0;
        end
      end
      S_RUN: begin
        k_d = k_q + KW'(1);
        if (last_k) begin
          k_d    = '0;
          y_d    = y_q + YW'(1);
          base_d = base_q + W_A;
          if (last_y) begin
            state_d = S_DRAIN;
            y_d     = '0;
            base_d  = '0;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_IDLE;
          drain_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      drain_q    <= 1'b0;
      en_q       <= '0;
      l_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
      win_q      <= '0;
      wr_addr_q  <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      y_q        <= y_d;
      base_q     <= base_d;
      drain_q    <= drain_d;
      en_q       <= en_d;
      l_q        <= l_d;
      m_q        <= m_d;
      r_q        <= r_d;
      win_q      <= win_d;
      wr_addr_q  <= wr_addr_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  // L is the oldest column; it exists only to make the shift structure explicit.
  logic unused_l;
  assign unused_l = ^l_q;

  assign start     = (state_q == S_IDLE) && go && !rst;
  assign busy      = (state_q != S_IDLE) || start;
  assign cnt_start = run && (y_q == '0) && (k_q == KW'(1));
  assign done      = run && last_y && last_k;
  assign rd_en0    = rd_en[0];
  assign rd_en1    = rd_en[1];
  assign rd_en2    = rd_en[2];
  assign rd_addr0  = rd_addr[0];
  assign rd_addr1  = rd_addr[1];
  assign rd_addr2  = rd_addr[2];
  assign win_row0  = win_q[0];
  assign win_row1  = win_q[1];
  assign win_row2  = win_q[2];
  assign wr_addr   = wr_addr_q;
  assign wr_valid  = wr_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_img_window_feeder.sv
// Scoreboard bench for img_window_feeder on a 4x3 image whose pixel value is address+1.
`default_nettype none

module tb_img_window_feeder;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int AW  = 8;
  localparam int ROW = W + 2;

  logic clk = 1'b0;
  logic rst, go;
  logic busy, start, cnt_start, done, rd_en0, rd_en1, rd_en2, wr_valid;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, wr_addr;
  logic [11:0] rd_data0, rd_data1, rd_data2;
  logic [35:0] win_row0, win_row1, win_row2;
  logic [147:0] all_out;

  typedef struct {
    logic [AW-1:0] addr;
    logic [35:0]   w0, w1, w2;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  img_window_feeder #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .start(start),
    .cnt_start(cnt_start), .done(done),
    .rd_en0(rd_en0), .rd_en1(rd_en1), .rd_en2(rd_en2),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .win_row0(win_row0), .win_row1(win_row1), .win_row2(win_row2),
    .wr_addr(wr_addr), .wr_valid(wr_valid)
  );

  assign all_out = {busy, start, cnt_start, done, rd_en0, rd_en1, rd_en2,
                    rd_addr0, rd_addr1, rd_addr2, win_row0, win_row1, win_row2,
                    wr_addr, wr_valid};

  // Source memory: one-cycle latency, junk on the bus when not read.
  always @(posedge clk) begin
    rd_data0 <= rd_en0 ? ({4'h0, rd_addr0} + 12'd1) : 12'hBAD;
    rd_data1 <= rd_en1 ? ({4'h0, rd_addr1} + 12'd1) : 12'hBAD;
    rd_data2 <= rd_en2 ? ({4'h0, rd_addr2} + 12'd1) : 12'hBAD;
  end

  function automatic logic [11:0] pix(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 12'h000;
    return 12'(r * W + c + 1);
  endfunction

  function automatic logic [35:0] wrow(input int r, input int x);
    return {pix(r, x - 1), pix(r, x), pix(r, x + 1)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    rst = 1'b0;
  endtask

  task automatic do_pass(input bit poke_go, input string tag);
    int cnt_cyc = -1, cnt_n = 0, done_cyc = -1, done_n = 0;
    int win_n = 0, busy_low = -1, rd_err = 0;
    bit exp_v;
    exp_t e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.addr = AW'(y * W + x);
        e.w0   = wrow(y - 1, x);
        e.w1   = wrow(y, x);
        e.w2   = wrow(y + 1, x);
        sb.push_back(e);
      end
    @(negedge clk);
    go = 1'b1;
    #1;
    total++;
    if (start !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s start_busy got=%b%b want=11", tag, start, busy);
    end
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (poke_go && c == 8) begin
        go = 1'b1;
        #1;
        total++;
        if (start !== 1'b0) begin
          bad++;
          $display("FAIL %s start_while_busy got=%b want=0", tag, start);
        end
      end
      if (cnt_start === 1'b1) begin cnt_n++; if (cnt_cyc < 0) cnt_cyc = c; end
      if (done === 1'b1) begin done_n++; if (done_cyc < 0) done_cyc = c; end
      if (busy_low < 0 && busy !== 1'b1) busy_low = c;
      if (c < ROW && rd_en0 !== 1'b0) rd_err++;
      if (c >= 2 * ROW && c < 3 * ROW && rd_en2 !== 1'b0) rd_err++;
      exp_v = (c >= 1 && c <= 3 * ROW && ((c - 1) % ROW) >= 2);
      total++;
      if (wr_valid !== exp_v) begin
        bad++;
        $display("FAIL %s wr_valid cyc=%0d got=%b want=%b", tag, c, wr_valid, exp_v);
      end
      if (wr_valid === 1'b1) begin
        win_n++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL %s extra_window cyc=%0d got=addr %h want=none", tag, c, wr_addr);
        end else begin
          e = sb.pop_front();
          if (wr_addr !== e.addr || win_row0 !== e.w0 || win_row1 !== e.w1 || win_row2 !== e.w2) begin
            bad++;
            $display("FAIL %s window got=%h %h %h %h want=%h %h %h %h", tag,
                     wr_addr, win_row0, win_row1, win_row2, e.addr, e.w0, e.w1, e.w2);
          end
        end
      end
      @(negedge clk);
      go = 1'b0;
    end
    total++;
    if (win_n != W * H || sb.size() != 0) begin
      bad++;
      $display("FAIL %s window_count got=%0d left=%0d want=%0d", tag, win_n, sb.size(), W * H);
      sb.delete();
    end
    total++;
    if (cnt_cyc != 1 || cnt_n != 1) begin
      bad++;
      $display("FAIL %s cnt_start got=cyc%0d n%0d want=cyc1 n1", tag, cnt_cyc, cnt_n);
    end
    total++;
    if (done_cyc != H * ROW - 1 || done_n != 1) begin
      bad++;
      $display("FAIL %s done got=cyc%0d n%0d want=cyc%0d n1", tag, done_cyc, done_n, H * ROW - 1);
    end
    total++;
    if (busy_low != H * ROW + 2) begin
      bad++;
      $display("FAIL %s busy_fall got=%0d want=%0d", tag, busy_low, H * ROW + 2);
    end
    total++;
    if (rd_err != 0) begin
      bad++;
      $display("FAIL %s edge_row_read got=%0d want=0", tag, rd_err);
    end
  endtask

  task automatic test_abort();
    int stray = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (ROW + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL abort_outputs got=%h want=0", all_out);
    end
    rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (done !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0) stray++;
      @(negedge clk);
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL abort_quiet got=%0d want=0", stray);
    end
    do_pass(1'b0, "after_abort");
  endtask

  task automatic test_rst_go();
    @(negedge clk);
    rst = 1'b1;
    go  = 1'b1;
    #1;
    total++;
    if (start !== 1'b0) begin
      bad++;
      $display("FAIL rst_go_start got=%b want=0", start);
    end
    @(negedge clk);
    rst = 1'b0;
    go  = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || rd_en1 !== 1'b0) begin
      bad++;
      $display("FAIL rst_go_dropped got=%b%b want=00", busy, rd_en1);
    end
  endtask

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    test_reset();
    do_pass(1'b0, "basic");
    do_pass(1'b1, "go_ignored");
    test_abort();
    test_rst_go();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
